// File: rtl/sdram_write_buffer.sv
// Write-side buffer between the SD card loader and the SDRAM controller.
// Loader words are queued in a small FIFO and drained as Avalon-MM single-word writes.
module sdram_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 25
) (
  input  logic                    clk50,
  input  logic                    reset,
  input  logic                    ram_we,
  input  logic [ADDR_W-1:0]       ram_address,
  input  logic [15:0]             ram_data,
  output logic                    ram_op_begun,
  input  logic                    init_done_i,
  output logic [ADDR_W-1:0]       avm_address,
  output logic                    avm_write,
  output logic [15:0]             avm_writedata,
  output logic [1:0]              avm_byteenable,
  input  logic                    avm_waitrequest,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic [ADDR_W-1:0]       words_written,
  output logic                    seq_error,
  output logic                    flush_done
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = ADDR_W + 16;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [ADDR_W-1:0]  expected_q, expected_d;
  logic [ADDR_W-1:0]  words_written_q, words_written_d;
  logic               seq_error_q, seq_error_d;
  logic               flush_done_q, flush_done_d;

  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] head;

  // A full FIFO refuses the push even if a pop frees a slot on the same edge.
  assign push = ram_we && (count_q != FULL);
  assign pop  = (count_q != '0) && !avm_waitrequest;
  assign head = mem_q[rd_ptr_q];

  always_comb begin
    mem_d           = mem_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    count_d         = count_q;
    expected_d      = expected_q;
    words_written_d = words_written_q;
    seq_error_d     = seq_error_q;
    flush_done_d    = flush_done_q;

    if (push) begin
      mem_d[wr_ptr_q] = {ram_address, ram_data};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      // After a gap the check resynchronises to the new address.
      expected_d      = ram_address + ADDR_W'(1);
      if (ram_address != expected_q) begin
        seq_error_d = 1'b1;
      end
    end

    if (pop) begin
      rd_ptr_d        = rd_ptr_q + PTR_W'(1);
      words_written_d = words_written_q + ADDR_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (init_done_i && (count_q == '0) && !push) begin
      flush_done_d = 1'b1;
    end
  end

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      expected_q      <= '0;
      words_written_q <= '0;
      seq_error_q     <= 1'b0;
      flush_done_q    <= 1'b0;
    end else begin
      mem_q           <= mem_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      expected_q      <= expected_d;
      words_written_q <= words_written_d;
      seq_error_q     <= seq_error_d;
      flush_done_q    <= flush_done_d;
    end
  end

  assign ram_op_begun   = push;
  assign avm_write      = (count_q != '0);
  assign avm_address    = head[ENTRY_W-1:16];
  assign avm_writedata  = head[15:0];
  assign avm_byteenable = 2'b11;
  assign fifo_count     = count_q;
  assign words_written  = words_written_q;
  assign seq_error      = seq_error_q;
  assign flush_done     = flush_done_q;

endmodule
